// File: rtl/change_dispenser.sv
// change_dispenser
//   Converts a change value (in 1-jiao units) into a train of one-hot coin-eject
//   pulses for the coin hopper. Coins are chosen greedily (1 yuan, 5 jiao, 1 jiao)
//   and only from denominations still in stock; an unpaid residue raises o_short.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   i_start        dispense request (accepted only when idle)
//   i_amount       change value in jiao, sampled with i_start
//   i_refill       inventory load (accepted only when idle, loses to i_start)
//   i_refill_cnt*  new inventory per denomination
//   o_coin         eject pulse, [0]=1 jiao, [1]=5 jiao, [2]=1 yuan
//   o_busy         high whenever a request is in progress
//   o_remain       value still to be paid out
//   o_done         one-cycle completion pulse
//   o_short        last request ended unpaid; held until the next accepted start
//   o_cnt*         current inventory per denomination
module change_dispenser #(
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned GAP_LEN   = 2,
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned INIT_CNT  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [4:0]       i_amount,
    input  logic             i_refill,
    input  logic [CNT_W-1:0] i_refill_cnt10,
    input  logic [CNT_W-1:0] i_refill_cnt5,
    input  logic [CNT_W-1:0] i_refill_cnt1,
    output logic [2:0]       o_coin,
    output logic             o_busy,
    output logic [4:0]       o_remain,
    output logic             o_done,
    output logic             o_short,
    output logic [CNT_W-1:0] o_cnt10,
    output logic [CNT_W-1:0] o_cnt5,
    output logic [CNT_W-1:0] o_cnt1
);

    localparam int unsigned TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_LEN - 1);

    typedef enum logic [2:0] {StIdle, StSelect, StPulse, StGap, StDone} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       coin_q, coin_d;
    logic [4:0]       remain_q, remain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [CNT_W-1:0] cnt10_q, cnt10_d;
    logic [CNT_W-1:0] cnt5_q, cnt5_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Greedy choice: a denomination qualifies only if it fits and is in stock,
    // which is also what keeps the counters from underflowing.
    logic sel10, sel5, sel1, sel_any;
    assign sel10   = (remain_q >= 5'd10) && (cnt10_q != '0);
    assign sel5    = (remain_q >= 5'd5) && (cnt5_q != '0);
    assign sel1    = (remain_q != 5'd0) && (cnt1_q != '0);
    assign sel_any = sel10 || sel5 || sel1;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            coin_q   <= '0;
            remain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            cnt10_q  <= CNT_W'(INIT_CNT);
            cnt5_q   <= CNT_W'(INIT_CNT);
            cnt1_q   <= CNT_W'(INIT_CNT);
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            coin_q   <= coin_d;
            remain_q <= remain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            short_q  <= short_d;
            cnt10_q  <= cnt10_d;
            cnt5_q   <= cnt5_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StSelect;
            end
            StSelect: begin
                state_d = sel_any ? StPulse : StDone;
            end
            StPulse: begin
                if (timer_q == PULSE_LAST) state_d = StGap;
            end
            StGap: begin
                if (timer_q == GAP_LAST) state_d = StSelect;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        timer_d  = timer_q;
        coin_d   = coin_q;
        remain_d = remain_q;
        short_d  = short_q;
        cnt10_d  = cnt10_q;
        cnt5_d   = cnt5_q;
        cnt1_d   = cnt1_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    remain_d = i_amount;
                    short_d  = 1'b0;
                end else if (i_refill) begin
                    cnt10_d = i_refill_cnt10;
                    cnt5_d  = i_refill_cnt5;
                    cnt1_d  = i_refill_cnt1;
                end
            end
            StSelect: begin
                timer_d = '0;
                if (sel10) begin
                    coin_d   = 3'b100;
                    remain_d = remain_q - 5'd10;
                    cnt10_d  = cnt10_q - CNT_W'(1);
                end else if (sel5) begin
                    coin_d   = 3'b010;
                    remain_d = remain_q - 5'd5;
                    cnt5_d   = cnt5_q - CNT_W'(1);
                end else if (sel1) begin
                    coin_d   = 3'b001;
                    remain_d = remain_q - 5'd1;
                    cnt1_d   = cnt1_q - CNT_W'(1);
                end else begin
                    // Nothing left to pay, or nothing payable: residue decides.
                    short_d = (remain_q != 5'd0);
                end
            end
            StPulse: begin
                if (timer_q == PULSE_LAST) begin
                    coin_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StGap: begin
                if (timer_q == GAP_LAST) timer_d = '0;
                else                     timer_d = timer_q + TW'(1);
            end
            StDone: ;
            default: ;
        endcase
    end

    // Flags derived from the upcoming state so they line up with it.
    assign busy_d = (state_d != StIdle);
    assign done_d = (state_d == StDone);

    assign o_coin   = coin_q;
    assign o_busy   = busy_q;
    assign o_remain = remain_q;
    assign o_done   = done_q;
    assign o_short  = short_q;
    assign o_cnt10  = cnt10_q;
    assign o_cnt5   = cnt5_q;
    assign o_cnt1   = cnt1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Self-checking bench for change_dispenser: directed cases plus randomized
//   requests, refills and busy-time noise, checked cycle by cycle against a
//   greedy change-making model and the documented pulse timing.
module tb_change_dispenser;

    localparam int P    = 2;
    localparam int G    = 2;
    localparam int CW   = 6;
    localparam int INIT = 8;
    localparam int L    = 1 + P + G;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic [4:0]    i_amount;
    logic          i_refill;
    logic [CW-1:0] i_refill_cnt10, i_refill_cnt5, i_refill_cnt1;
    logic [2:0]    o_coin;
    logic          o_busy, o_done, o_short;
    logic [4:0]    o_remain;
    logic [CW-1:0] o_cnt10, o_cnt5, o_cnt1;

    int n_total = 0;
    int n_bad   = 0;
    int m10, m5, m1;  // model inventory
    bit m_short;
    int m_remain;

    change_dispenser #(
        .PULSE_LEN(P),
        .GAP_LEN  (G),
        .CNT_W    (CW),
        .INIT_CNT (INIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_amount      (i_amount),
        .i_refill      (i_refill),
        .i_refill_cnt10(i_refill_cnt10),
        .i_refill_cnt5 (i_refill_cnt5),
        .i_refill_cnt1 (i_refill_cnt1),
        .o_coin        (o_coin),
        .o_busy        (o_busy),
        .o_remain      (o_remain),
        .o_done        (o_done),
        .o_short       (o_short),
        .o_cnt10       (o_cnt10),
        .o_cnt5        (o_cnt5),
        .o_cnt1        (o_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_inv(input string tag);
        check_eq({tag, " cnt10"}, int'(o_cnt10), m10);
        check_eq({tag, " cnt5"}, int'(o_cnt5), m5);
        check_eq({tag, " cnt1"}, int'(o_cnt1), m1);
    endtask

    task automatic do_refill(input int a, input int b, input int c);
        i_refill       = 1'b1;
        i_refill_cnt10 = CW'(a);
        i_refill_cnt5  = CW'(b);
        i_refill_cnt1  = CW'(c);
        tick();
        i_refill = 1'b0;
        m10 = a;
        m5  = b;
        m1  = c;
        check_inv("refill");
        check_eq("refill busy", int'(o_busy), 0);
    endtask

    // One full request. noise: random start/refill while busy.
    // with_refill: refill raised together with start (must be dropped).
    task automatic run_req(input int amount, input bit noise, input bit with_refill);
        int codes[$];
        int rem, n, last, idx, off, exp_coin;
        rem = amount;
        codes.delete();
        while (rem > 0) begin
            if (rem >= 10 && m10 > 0) begin
                codes.push_back(4); rem -= 10; m10--;
            end else if (rem >= 5 && m5 > 0) begin
                codes.push_back(2); rem -= 5; m5--;
            end else if (m1 > 0) begin
                codes.push_back(1); rem -= 1; m1--;
            end else begin
                break;
            end
        end
        n        = codes.size();
        last     = n * L + 2;
        m_remain = rem;
        m_short  = (rem != 0);

        i_start  = 1'b1;
        i_amount = 5'(amount);
        if (with_refill) begin
            i_refill       = 1'b1;
            i_refill_cnt10 = CW'($urandom_range(0, 63));
            i_refill_cnt5  = CW'($urandom_range(0, 63));
            i_refill_cnt1  = CW'($urandom_range(0, 63));
        end
        tick();
        i_start  = 1'b0;
        i_refill = 1'b0;

        for (int t = 1; t <= last; t++) begin
            idx      = (t - 1) / L;
            off      = (t - 1) % L;
            exp_coin = (idx < n && off >= 1 && off <= P) ? codes[idx] : 0;
            check_eq($sformatf("coin a=%0d t=%0d", amount, t), int'(o_coin), exp_coin);
            check_eq($sformatf("busy a=%0d t=%0d", amount, t), int'(o_busy), 1);
            check_eq($sformatf("done a=%0d t=%0d", amount, t), int'(o_done), int'(t == last));
            if (t == 1) begin
                check_eq("remain latched", int'(o_remain), amount);
                check_eq("short cleared", int'(o_short), 0);
            end
            if (t == last) begin
                check_eq("remain at done", int'(o_remain), m_remain);
                check_eq("short at done", int'(o_short), int'(m_short));
                check_inv("at done");
            end
            if (noise && t <= last - 1) begin
                i_start        = 1'($urandom_range(0, 1));
                i_amount       = 5'($urandom_range(0, 31));
                i_refill       = 1'($urandom_range(0, 1));
                i_refill_cnt10 = CW'($urandom_range(0, 63));
                i_refill_cnt5  = CW'($urandom_range(0, 63));
                i_refill_cnt1  = CW'($urandom_range(0, 63));
            end else begin
                i_start  = 1'b0;
                i_refill = 1'b0;
            end
            tick();
        end
        check_eq("idle busy", int'(o_busy), 0);
        check_eq("idle done", int'(o_done), 0);
        check_eq("idle coin", int'(o_coin), 0);
        tick();
        check_eq("short held", int'(o_short), int'(m_short));
        check_eq("remain held", int'(o_remain), m_remain);
        check_inv("idle");
    endtask

    initial begin
        reset          = 1'b1;
        i_start        = 1'b0;
        i_amount       = '0;
        i_refill       = 1'b0;
        i_refill_cnt10 = '0;
        i_refill_cnt5  = '0;
        i_refill_cnt1  = '0;
        m10 = INIT; m5 = INIT; m1 = INIT;
        tick();
        tick();
        check_eq("rst coin", int'(o_coin), 0);
        check_eq("rst busy", int'(o_busy), 0);
        check_eq("rst remain", int'(o_remain), 0);
        check_eq("rst done", int'(o_done), 0);
        check_eq("rst short", int'(o_short), 0);
        check_inv("rst");
        reset = 1'b0;
        tick();

        // T1: 17 -> 10,5,1,1
        run_req(17, 1'b0, 1'b0);
        check_eq("T1 cnt10", int'(o_cnt10), 7);
        check_eq("T1 cnt5", int'(o_cnt5), 7);
        check_eq("T1 cnt1", int'(o_cnt1), 6);

        // T2: no 1-yuan coins, 15 -> three 5-jiao coins
        do_refill(0, 8, 8);
        run_req(15, 1'b0, 1'b0);
        check_eq("T2 cnt5", int'(o_cnt5), 5);
        check_eq("T2 short", int'(o_short), 0);

        // T3: only one 1-jiao coin, 3 -> shortfall of 2
        do_refill(0, 0, 1);
        run_req(3, 1'b0, 1'b0);
        check_eq("T3 remain", int'(o_remain), 2);
        check_eq("T3 short", int'(o_short), 1);
        check_eq("T3 cnt1", int'(o_cnt1), 0);

        // T4: zero amount, done two edges after start
        run_req(0, 1'b0, 1'b0);

        // T5: reset during the second cycle of the first pulse
        do_refill(8, 8, 8);
        i_start  = 1'b1;
        i_amount = 5'd20;
        tick();
        i_start = 1'b0;
        tick();
        check_eq("T5 first coin", int'(o_coin), 4);
        tick();
        check_eq("T5 second pulse cycle", int'(o_coin), 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m10 = INIT; m5 = INIT; m1 = INIT;
        check_eq("T5 coin", int'(o_coin), 0);
        check_eq("T5 busy", int'(o_busy), 0);
        check_eq("T5 remain", int'(o_remain), 0);
        check_inv("T5");

        // T6: noise while busy, plus start+refill together
        run_req(28, 1'b1, 1'b1);
        run_req(31, 1'b1, 1'b0);

        // Randomized requests
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    do_refill($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5));
                else
                    do_refill($urandom_range(0, 63), $urandom_range(0, 63),
                              $urandom_range(0, 63));
            end
            run_req($urandom_range(0, 31), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
